// File: rtl/oka_pkg.sv
// Shared types and helpers for the Karatsuba-style even/odd carry-less multiplier.
// Holds the FSM state encoding and the bit-spreading function S.
package oka_pkg;

    typedef enum logic [2:0] {
        IDLE,
        P_E,
        P_O,
        P_M,
        DONE
    } oka_state_t;

    // Widest half-product S() must handle; supports operand widths up to 128.
    localparam int SPREAD_IN_W = 128;

    // S(v): bit i of v lands on bit 2i, odd positions are zero.
    function automatic logic [2*SPREAD_IN_W-1:0] spread(input logic [SPREAD_IN_W-1:0] v);
        logic [2*SPREAD_IN_W-1:0] r;
        r = '0;
        for (int i = 0; i < SPREAD_IN_W; i++) begin
            r[2*i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/clmul_comb.sv
// Combinational W x W schoolbook carry-less multiplier; product is 2W-1 bits.
module clmul_comb #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-2:0] p
);

    // acc[k] holds the XOR of the first k shifted partial products.
    logic [2*W-2:0] acc [0:W];

    assign acc[0] = '0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_row
            assign acc[gi+1] = acc[gi] ^ (((2*W-1)'(a) << gi) & {(2*W-1){b[gi]}});
        end
    endgenerate

    assign p = acc[W];

endmodule

// File: rtl/oka_mult_seq.sv
// Sequential GF(2)[x] multiplier: three half products computed one per cycle on a
// shared N/2-bit multiplier, recombined through the even/odd spread identity.
module oka_mult_seq
    import oka_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y
);

    localparam int H   = N / 2;
    localparam int P_W = N - 1;
    localparam int Y_W = 2 * N - 1;

    oka_state_t     state_reg;
    oka_state_t     state_next;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [P_W-1:0] ce_reg;
    logic [P_W-1:0] co_reg;
    logic [Y_W-1:0] y_reg;
    logic [Y_W-1:0] y_next;

    logic [H-1:0]   ae, ao, be, bo;
    logic [H-1:0]   mul_a, mul_b;
    logic [P_W-1:0] mul_p;
    logic [P_W-1:0] mid;

    generate
        for (genvar gi = 0; gi < H; gi++) begin : g_split
            assign ae[gi] = a_reg[2*gi];
            assign ao[gi] = a_reg[2*gi+1];
            assign be[gi] = b_reg[2*gi];
            assign bo[gi] = b_reg[2*gi+1];
        end
    endgenerate

    // Operand select for the shared multiplier, keyed on the product being formed.
    always_comb begin
        mul_a = ae;
        mul_b = be;
        case (state_reg)
            P_O: begin
                mul_a = ao;
                mul_b = bo;
            end
            P_M: begin
                mul_a = ae ^ ao;
                mul_b = be ^ bo;
            end
            default: ;
        endcase
    end

    clmul_comb #(
        .W(H)
    ) u_clmul (
        .a(mul_a),
        .b(mul_b),
        .p(mul_p)
    );

    // In P_M the multiplier output is M; the cross term is M ^ Ce ^ Co.
    assign mid    = mul_p ^ ce_reg ^ co_reg;
    assign y_next = Y_W'(spread(SPREAD_IN_W'(ce_reg))
                       ^ (spread(SPREAD_IN_W'(mid)) << 1)
                       ^ (spread(SPREAD_IN_W'(co_reg)) << 2));

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = P_E;
            end
            P_E:  state_next = P_O;
            P_O:  state_next = P_M;
            P_M:  state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            ce_reg    <= '0;
            co_reg    <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                    end
                end
                P_E:     ce_reg <= mul_p;
                P_O:     co_reg <= mul_p;
                P_M:     y_reg  <= y_next;
                default: ;
            endcase
        end
    end

    assign y = y_reg;

endmodule

// File: tb/tb_oka_mult_seq.sv
// Bench for oka_mult_seq: three instances (N=8, 16, 32) driven in lockstep with the
// same handshakes; directed vectors, latency, backpressure, reset abort, random traffic.
module tb_oka_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a32;
    logic [31:0] b32;

    logic        in_ready8, in_ready16, in_ready32;
    logic        out_valid8, out_valid16, out_valid32;
    logic [14:0] y8;
    logic [30:0] y16;
    logic [62:0] y32;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    oka_mult_seq #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a32[15:0]), .b(b32[15:0]), .out_valid(out_valid16),
        .out_ready(out_ready), .y(y16)
    );

    oka_mult_seq #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a32[7:0]), .b(b32[7:0]), .out_valid(out_valid8),
        .out_ready(out_ready), .y(y8)
    );

    oka_mult_seq #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a32), .b(b32), .out_valid(out_valid32),
        .out_ready(out_ready), .y(y32)
    );

    // Reference: plain shift-and-XOR polynomial product of the low n bits.
    function automatic logic [63:0] clmul_ref(input logic [31:0] x, input logic [31:0] z, input int n);
        logic [63:0] r;
        logic [63:0] xm;
        r  = '0;
        xm = 64'(x);
        if (n < 32) xm = xm & ((64'd1 << n) - 64'd1);
        for (int i = 0; i < n; i++) begin
            if (z[i]) r = r ^ (xm << i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_y(input string tag, input logic [31:0] av, input logic [31:0] bv);
        check({tag, "_y8"},  64'(y8),  clmul_ref(av, bv, 8));
        check({tag, "_y16"}, 64'(y16), clmul_ref(av, bv, 16));
        check({tag, "_y32"}, 64'(y32), clmul_ref(av, bv, 32));
    endtask

    // One full transaction with out_ready high; checks latency and the N=16 product.
    task automatic apply_op(input logic [31:0] av, input logic [31:0] bv,
                            input logic [63:0] exp16, input string tag);
        int lat;
        @(negedge clk);
        a32 = av; b32 = bv; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready16), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; a32 = $urandom; b32 = $urandom;
        lat = 0;
        while (!out_valid16 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_y16_exp"}, 64'(y16), exp16);
        check_all_y(tag, av, bv);
        @(negedge clk);
        check({tag, "_post_valid"}, 64'(out_valid16), 64'd0);
        check({tag, "_post_ready"}, 64'(in_ready16), 64'd1);
        $display("op %s a=0x%08h b=0x%08h y16=0x%0h lat=%0d", tag, av, bv, y16, lat);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [30:0] y;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[6];
        pair_t       sb[$];
        pair_t       p;
        logic [30:0] held;
        logic [31:0] ra, rb;
        int          accepted, retired, cyc;
        logic        stray;

        vecs[0] = '{16'h0003, 16'h0003, 31'h00000005};
        vecs[1] = '{16'h8000, 16'h8000, 31'h40000000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 31'h55555555};
        vecs[3] = '{16'h0000, 16'hBEEF, 31'h00000000};
        vecs[4] = '{16'h0001, 16'hBEEF, 31'h0000BEEF};
        vecs[5] = '{16'h0002, 16'h8001, 31'h00010002};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a32 = '0; b32 = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready16),  64'd1);
        check("rst_out_valid", 64'(out_valid16), 64'd0);
        check("rst_y",         64'(y16),         64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply_op({16'h0, vecs[i].a}, {16'h0, vecs[i].b}, 64'(vecs[i].y), $sformatf("vec%0d", i));
        end

        // Backpressure: result and flags must hold while out_ready is low, with
        // a competing in_valid present the whole time.
        @(negedge clk);
        ra = 32'hA5C3_1E77; rb = 32'h3C96_F00D;
        a32 = ra; b32 = rb; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
        repeat (3) @(negedge clk);
        check("bp_valid_start", 64'(out_valid16), 64'd1);
        held = y16;
        check("bp_y_start", 64'(held), clmul_ref(ra, rb, 16));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_y_c%0d", c),     64'(y16),        64'(held));
            check($sformatf("bp_valid_c%0d", c), 64'(out_valid16), 64'd1);
            check($sformatf("bp_ready_c%0d", c), 64'(in_ready16),  64'd0);
        end
        check_all_y("bp", ra, rb);
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("bp_release_valid", 64'(out_valid16), 64'd0);
        check("bp_release_ready", 64'(in_ready16),  64'd1);
        $display("op backpressure a=0x%08h b=0x%08h y16=0x%0h", ra, rb, held);

        // Reset while the second half product is being formed.
        @(negedge clk);
        a32 = 32'hDEAD_BEEF; b32 = 32'hCAFE_F00D; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 64'(out_valid16), 64'd0);
        check("mrst_in_ready",  64'(in_ready16),  64'd1);
        check("mrst_y",         64'(y16),         64'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid16 || out_valid8 || out_valid32) stray = 1'b1;
        end
        check("mrst_no_result", 64'(stray), 64'd0);
        $display("op midreset aborted stray=%0d", stray);
        ra = $urandom; rb = $urandom;
        apply_op(ra, rb, clmul_ref(ra, rb, 16), "after_rst");

        // Random traffic with gaps on both sides, scoreboarded.
        accepted = 0; retired = 0; cyc = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        while ((accepted < 1000 || sb.size() > 0) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a32 = $urandom; b32 = $urandom;
            if (in_valid && in_ready16) begin
                p.a = a32; p.b = b32;
                sb.push_back(p);
                accepted++;
            end
            if (out_valid16 && out_ready) begin
                check("rand_no_dup", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    p = sb.pop_front();
                    check("rand_valid8",  64'(out_valid8),  64'd1);
                    check("rand_valid32", 64'(out_valid32), 64'd1);
                    check_all_y("rand", p.a, p.b);
                    retired++;
                    $display("rand %0d a=0x%08h b=0x%08h y32=0x%0h", retired, p.a, p.b, y32);
                end
            end
        end
        in_valid = 1'b0;
        check("rand_accepted", 64'(accepted), 64'd1000);
        check("rand_retired",  64'(retired),  64'd1000);
        check("rand_leftover", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
